// File: rtl/hp_port_arbiter.sv
// Two-master AXI4 arbiter onto the shared Zynq HP slave port. Read and write channels are arbitrated independently, round-robin, one burst each.
// Optional master-0 DRAM window remap is enabled with `define HP_ARB_REMAP_EN.
module hp_port_arbiter #(
  parameter int unsigned ID_W   = 6,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  // master 0 (Rocket)
  input  logic                m0_ar_valid,
  input  logic [31:0]         m0_ar_addr,
  input  logic [ID_W-1:0]     m0_ar_id,
  input  logic [7:0]          m0_ar_len,
  input  logic [2:0]          m0_ar_size,
  input  logic [1:0]          m0_ar_burst,
  output logic                m0_ar_ready,
  output logic                m0_r_valid,
  output logic [DATA_W-1:0]   m0_r_data,
  output logic [ID_W-1:0]     m0_r_id,
  output logic [1:0]          m0_r_resp,
  output logic                m0_r_last,
  input  logic                m0_r_ready,
  input  logic                m0_aw_valid,
  input  logic [31:0]         m0_aw_addr,
  input  logic [ID_W-1:0]     m0_aw_id,
  input  logic [7:0]          m0_aw_len,
  input  logic [2:0]          m0_aw_size,
  input  logic [1:0]          m0_aw_burst,
  output logic                m0_aw_ready,
  input  logic                m0_w_valid,
  input  logic [DATA_W-1:0]   m0_w_data,
  input  logic [DATA_W/8-1:0] m0_w_strb,
  input  logic                m0_w_last,
  output logic                m0_w_ready,
  output logic                m0_b_valid,
  output logic [ID_W-1:0]     m0_b_id,
  output logic [1:0]          m0_b_resp,
  input  logic                m0_b_ready,
  // master 1 (VDMA)
  input  logic                m1_ar_valid,
  input  logic [31:0]         m1_ar_addr,
  input  logic [ID_W-1:0]     m1_ar_id,
  input  logic [7:0]          m1_ar_len,
  input  logic [2:0]          m1_ar_size,
  input  logic [1:0]          m1_ar_burst,
  output logic                m1_ar_ready,
  output logic                m1_r_valid,
  output logic [DATA_W-1:0]   m1_r_data,
  output logic [ID_W-1:0]     m1_r_id,
  output logic [1:0]          m1_r_resp,
  output logic                m1_r_last,
  input  logic                m1_r_ready,
  input  logic                m1_aw_valid,
  input  logic [31:0]         m1_aw_addr,
  input  logic [ID_W-1:0]     m1_aw_id,
  input  logic [7:0]          m1_aw_len,
  input  logic [2:0]          m1_aw_size,
  input  logic [1:0]          m1_aw_burst,
  output logic                m1_aw_ready,
  input  logic                m1_w_valid,
  input  logic [DATA_W-1:0]   m1_w_data,
  input  logic [DATA_W/8-1:0] m1_w_strb,
  input  logic                m1_w_last,
  output logic                m1_w_ready,
  output logic                m1_b_valid,
  output logic [ID_W-1:0]     m1_b_id,
  output logic [1:0]          m1_b_resp,
  input  logic                m1_b_ready,
  // HP slave port
  output logic                s_ar_valid,
  output logic [31:0]         s_ar_addr,
  output logic [ID_W-1:0]     s_ar_id,
  output logic [7:0]          s_ar_len,
  output logic [2:0]          s_ar_size,
  output logic [1:0]          s_ar_burst,
  output logic [3:0]          s_ar_cache,
  output logic [2:0]          s_ar_prot,
  output logic [3:0]          s_ar_qos,
  output logic                s_ar_lock,
  input  logic                s_ar_ready,
  input  logic                s_r_valid,
  input  logic [DATA_W-1:0]   s_r_data,
  input  logic [ID_W-1:0]     s_r_id,
  input  logic [1:0]          s_r_resp,
  input  logic                s_r_last,
  output logic                s_r_ready,
  output logic                s_aw_valid,
  output logic [31:0]         s_aw_addr,
  output logic [ID_W-1:0]     s_aw_id,
  output logic [7:0]          s_aw_len,
  output logic [2:0]          s_aw_size,
  output logic [1:0]          s_aw_burst,
  output logic [3:0]          s_aw_cache,
  output logic [2:0]          s_aw_prot,
  output logic [3:0]          s_aw_qos,
  output logic                s_aw_lock,
  input  logic                s_aw_ready,
  output logic                s_w_valid,
  output logic [DATA_W-1:0]   s_w_data,
  output logic [DATA_W/8-1:0] s_w_strb,
  output logic                s_w_last,
  input  logic                s_w_ready,
  input  logic                s_b_valid,
  input  logic [ID_W-1:0]     s_b_id,
  input  logic [1:0]          s_b_resp,
  output logic                s_b_ready,
  // debug
  output logic                rd_owner,
  output logic                wr_owner
);

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic      rd_owner_q, rd_owner_d, rd_ptr_q, rd_ptr_d;
  logic      wr_owner_q, wr_owner_d, wr_ptr_q, wr_ptr_d;

  function automatic logic [31:0] m0_remap(input logic [31:0] a);
`ifdef HP_ARB_REMAP_EN
    m0_remap = (a[31:28] == 4'd2) ? {4'd4, a[27:0]} : {4'd1, a[27:0]};
`else
    m0_remap = a;
`endif
  endfunction

  // Round-robin: with both requesting the pointer wins, a lone requester always wins.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_owner_d = rd_owner_q;
    rd_ptr_d   = rd_ptr_q;
    unique case (rd_state_q)
      RD_IDLE: if (m0_ar_valid || m1_ar_valid) begin
        rd_owner_d = (m0_ar_valid && m1_ar_valid) ? rd_ptr_q : m1_ar_valid;
        rd_state_d = RD_ADDR;
      end
      RD_ADDR: if (s_ar_valid && s_ar_ready) rd_state_d = RD_DATA;
      RD_DATA: if (s_r_valid && s_r_ready && s_r_last) begin
        rd_state_d = RD_IDLE;
        rd_ptr_d   = ~rd_owner_q;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_owner_d = wr_owner_q;
    wr_ptr_d   = wr_ptr_q;
    unique case (wr_state_q)
      WR_IDLE: if (m0_aw_valid || m1_aw_valid) begin
        wr_owner_d = (m0_aw_valid && m1_aw_valid) ? wr_ptr_q : m1_aw_valid;
        wr_state_d = WR_ADDR;
      end
      WR_ADDR: if (s_aw_valid && s_aw_ready) wr_state_d = WR_DATA;
      WR_DATA: if (s_w_valid && s_w_ready && s_w_last) wr_state_d = WR_RESP;
      WR_RESP: if (s_b_valid && s_b_ready) begin
        wr_state_d = WR_IDLE;
        wr_ptr_d   = ~wr_owner_q;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= RD_IDLE;
      rd_owner_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_state_q <= WR_IDLE;
      wr_owner_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_owner_q <= rd_owner_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_state_q <= wr_state_d;
      wr_owner_q <= wr_owner_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  logic rd_addr_ph, rd_data_ph, wr_addr_ph, wr_data_ph, wr_resp_ph;
  assign rd_addr_ph = (rd_state_q == RD_ADDR);
  assign rd_data_ph = (rd_state_q == RD_DATA);
  assign wr_addr_ph = (wr_state_q == WR_ADDR);
  assign wr_data_ph = (wr_state_q == WR_DATA);
  assign wr_resp_ph = (wr_state_q == WR_RESP);

  assign rd_owner = rd_owner_q;
  assign wr_owner = wr_owner_q;

  // Read address: granted AR forwarded combinationally while in ADDR.
  assign s_ar_valid  = rd_addr_ph && (rd_owner_q ? m1_ar_valid : m0_ar_valid);
  assign s_ar_addr   = rd_owner_q ? m1_ar_addr  : m0_remap(m0_ar_addr);
  assign s_ar_id     = rd_owner_q ? m1_ar_id    : m0_ar_id;
  assign s_ar_len    = rd_owner_q ? m1_ar_len   : m0_ar_len;
  assign s_ar_size   = rd_owner_q ? m1_ar_size  : m0_ar_size;
  assign s_ar_burst  = rd_owner_q ? m1_ar_burst : m0_ar_burst;
  assign s_ar_cache  = 4'b0011;
  assign s_ar_prot   = '0;
  assign s_ar_qos    = '0;
  assign s_ar_lock   = 1'b0;
  assign m0_ar_ready = rd_addr_ph && !rd_owner_q && s_ar_ready;
  assign m1_ar_ready = rd_addr_ph &&  rd_owner_q && s_ar_ready;

  // Read data: payload broadcast, valid/ready gated by the grant.
  assign m0_r_valid = rd_data_ph && !rd_owner_q && s_r_valid;
  assign m1_r_valid = rd_data_ph &&  rd_owner_q && s_r_valid;
  assign m0_r_data  = s_r_data;
  assign m1_r_data  = s_r_data;
  assign m0_r_id    = s_r_id;
  assign m1_r_id    = s_r_id;
  assign m0_r_resp  = s_r_resp;
  assign m1_r_resp  = s_r_resp;
  assign m0_r_last  = s_r_last;
  assign m1_r_last  = s_r_last;
  assign s_r_ready  = rd_data_ph && (rd_owner_q ? m1_r_ready : m0_r_ready);

  assign s_aw_valid  = wr_addr_ph && (wr_owner_q ? m1_aw_valid : m0_aw_valid);
  assign s_aw_addr   = wr_owner_q ? m1_aw_addr  : m0_remap(m0_aw_addr);
  assign s_aw_id     = wr_owner_q ? m1_aw_id    : m0_aw_id;
  assign s_aw_len    = wr_owner_q ? m1_aw_len   : m0_aw_len;
  assign s_aw_size   = wr_owner_q ? m1_aw_size  : m0_aw_size;
  assign s_aw_burst  = wr_owner_q ? m1_aw_burst : m0_aw_burst;
  assign s_aw_cache  = 4'b0011;
  assign s_aw_prot   = '0;
  assign s_aw_qos    = '0;
  assign s_aw_lock   = 1'b0;
  assign m0_aw_ready = wr_addr_ph && !wr_owner_q && s_aw_ready;
  assign m1_aw_ready = wr_addr_ph &&  wr_owner_q && s_aw_ready;

  assign s_w_valid  = wr_data_ph && (wr_owner_q ? m1_w_valid : m0_w_valid);
  assign s_w_data   = wr_owner_q ? m1_w_data : m0_w_data;
  assign s_w_strb   = wr_owner_q ? m1_w_strb : m0_w_strb;
  assign s_w_last   = wr_owner_q ? m1_w_last : m0_w_last;
  assign m0_w_ready = wr_data_ph && !wr_owner_q && s_w_ready;
  assign m1_w_ready = wr_data_ph &&  wr_owner_q && s_w_ready;

  assign m0_b_valid = wr_resp_ph && !wr_owner_q && s_b_valid;
  assign m1_b_valid = wr_resp_ph &&  wr_owner_q && s_b_valid;
  assign m0_b_id    = s_b_id;
  assign m1_b_id    = s_b_id;
  assign m0_b_resp  = s_b_resp;
  assign m1_b_resp  = s_b_resp;
  assign s_b_ready  = wr_resp_ph && (wr_owner_q ? m1_b_ready : m0_b_ready);

endmodule

// File: tb/tb_hp_port_arbiter.sv
// Directed bench for hp_port_arbiter: table of read grants plus hand sequences for write stall, concurrency and reset.
module tb_hp_port_arbiter;
  localparam int unsigned ID_W = 6;
  localparam int unsigned DATA_W = 64;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_last, m0_r_ready;
  logic [31:0] m0_ar_addr; logic [ID_W-1:0] m0_ar_id, m0_r_id; logic [7:0] m0_ar_len;
  logic [2:0] m0_ar_size; logic [1:0] m0_ar_burst, m0_r_resp; logic [DATA_W-1:0] m0_r_data;
  logic m0_aw_valid, m0_aw_ready, m0_w_valid, m0_w_last, m0_w_ready, m0_b_valid, m0_b_ready;
  logic [31:0] m0_aw_addr; logic [ID_W-1:0] m0_aw_id, m0_b_id; logic [7:0] m0_aw_len;
  logic [2:0] m0_aw_size; logic [1:0] m0_aw_burst, m0_b_resp;
  logic [DATA_W-1:0] m0_w_data; logic [DATA_W/8-1:0] m0_w_strb;

  logic m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_last, m1_r_ready;
  logic [31:0] m1_ar_addr; logic [ID_W-1:0] m1_ar_id, m1_r_id; logic [7:0] m1_ar_len;
  logic [2:0] m1_ar_size; logic [1:0] m1_ar_burst, m1_r_resp; logic [DATA_W-1:0] m1_r_data;
  logic m1_aw_valid, m1_aw_ready, m1_w_valid, m1_w_last, m1_w_ready, m1_b_valid, m1_b_ready;
  logic [31:0] m1_aw_addr; logic [ID_W-1:0] m1_aw_id, m1_b_id; logic [7:0] m1_aw_len;
  logic [2:0] m1_aw_size; logic [1:0] m1_aw_burst, m1_b_resp;
  logic [DATA_W-1:0] m1_w_data; logic [DATA_W/8-1:0] m1_w_strb;

  logic s_ar_valid, s_ar_ready, s_ar_lock, s_r_valid, s_r_last, s_r_ready;
  logic [31:0] s_ar_addr; logic [ID_W-1:0] s_ar_id, s_r_id; logic [7:0] s_ar_len;
  logic [2:0] s_ar_size, s_ar_prot; logic [1:0] s_ar_burst, s_r_resp;
  logic [3:0] s_ar_cache, s_ar_qos; logic [DATA_W-1:0] s_r_data;
  logic s_aw_valid, s_aw_ready, s_aw_lock, s_w_valid, s_w_last, s_w_ready, s_b_valid, s_b_ready;
  logic [31:0] s_aw_addr; logic [ID_W-1:0] s_aw_id, s_b_id; logic [7:0] s_aw_len;
  logic [2:0] s_aw_size, s_aw_prot; logic [1:0] s_aw_burst, s_b_resp;
  logic [3:0] s_aw_cache, s_aw_qos; logic [DATA_W-1:0] s_w_data; logic [DATA_W/8-1:0] s_w_strb;
  logic rd_owner, wr_owner;

  hp_port_arbiter #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_ar_valid(m0_ar_valid), .m0_ar_addr(m0_ar_addr), .m0_ar_id(m0_ar_id), .m0_ar_len(m0_ar_len),
    .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst), .m0_ar_ready(m0_ar_ready),
    .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data), .m0_r_id(m0_r_id), .m0_r_resp(m0_r_resp),
    .m0_r_last(m0_r_last), .m0_r_ready(m0_r_ready),
    .m0_aw_valid(m0_aw_valid), .m0_aw_addr(m0_aw_addr), .m0_aw_id(m0_aw_id), .m0_aw_len(m0_aw_len),
    .m0_aw_size(m0_aw_size), .m0_aw_burst(m0_aw_burst), .m0_aw_ready(m0_aw_ready),
    .m0_w_valid(m0_w_valid), .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb), .m0_w_last(m0_w_last),
    .m0_w_ready(m0_w_ready), .m0_b_valid(m0_b_valid), .m0_b_id(m0_b_id), .m0_b_resp(m0_b_resp),
    .m0_b_ready(m0_b_ready),
    .m1_ar_valid(m1_ar_valid), .m1_ar_addr(m1_ar_addr), .m1_ar_id(m1_ar_id), .m1_ar_len(m1_ar_len),
    .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst), .m1_ar_ready(m1_ar_ready),
    .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data), .m1_r_id(m1_r_id), .m1_r_resp(m1_r_resp),
    .m1_r_last(m1_r_last), .m1_r_ready(m1_r_ready),
    .m1_aw_valid(m1_aw_valid), .m1_aw_addr(m1_aw_addr), .m1_aw_id(m1_aw_id), .m1_aw_len(m1_aw_len),
    .m1_aw_size(m1_aw_size), .m1_aw_burst(m1_aw_burst), .m1_aw_ready(m1_aw_ready),
    .m1_w_valid(m1_w_valid), .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb), .m1_w_last(m1_w_last),
    .m1_w_ready(m1_w_ready), .m1_b_valid(m1_b_valid), .m1_b_id(m1_b_id), .m1_b_resp(m1_b_resp),
    .m1_b_ready(m1_b_ready),
    .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id), .s_ar_len(s_ar_len),
    .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_cache(s_ar_cache), .s_ar_prot(s_ar_prot),
    .s_ar_qos(s_ar_qos), .s_ar_lock(s_ar_lock), .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_id(s_r_id), .s_r_resp(s_r_resp),
    .s_r_last(s_r_last), .s_r_ready(s_r_ready),
    .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id), .s_aw_len(s_aw_len),
    .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_cache(s_aw_cache), .s_aw_prot(s_aw_prot),
    .s_aw_qos(s_aw_qos), .s_aw_lock(s_aw_lock), .s_aw_ready(s_aw_ready),
    .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_w_ready(s_w_ready), .s_b_valid(s_b_valid), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_b_ready(s_b_ready),
    .rd_owner(rd_owner), .wr_owner(wr_owner)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] rm(input logic [31:0] on, input logic [31:0] off);
`ifdef HP_ARB_REMAP_EN
    rm = on;
    if (off == 32'hFFFF_FFFF) rm = on;
`else
    rm = off;
    if (on == 32'hFFFF_FFFF) rm = off;
`endif
  endfunction

  task automatic chk_quiet(input string name);
    chk({name, "/handshakes"},
        {s_ar_valid, s_aw_valid, s_w_valid, s_r_ready, s_b_ready,
         m0_ar_ready, m1_ar_ready, m0_aw_ready, m1_aw_ready, m0_w_ready, m1_w_ready,
         m0_r_valid, m1_r_valid, m0_b_valid, m1_b_valid}, '0);
    chk({name, "/owners"}, {rd_owner, wr_owner}, 2'b00);
  endtask

  // One read burst from IDLE: entered and left at posedge+1.
  task automatic rd_txn(input string tag, input logic r0, input logic r1,
                        input logic [31:0] a0, input logic [31:0] a1, input logic [7:0] len,
                        input logic own, input logic [31:0] eaddr);
    logic [63:0] d;
    m0_ar_valid = r0; m1_ar_valid = r1;
    m0_ar_addr = a0;  m1_ar_addr = a1;
    m0_ar_len = len;  m1_ar_len = len;
    m0_ar_id = 6'd3;  m1_ar_id = 6'd12;
    #1 chk({tag, "/arvalid_idle"}, s_ar_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "/arvalid"}, s_ar_valid, 1'b1);
    chk({tag, "/rd_owner"}, rd_owner, own);
    chk({tag, "/ar_addr"}, s_ar_addr, eaddr);
    chk({tag, "/ar_len_id"}, {s_ar_len, s_ar_id}, {len, own ? 6'd12 : 6'd3});
    chk({tag, "/ar_cache"}, {s_ar_cache, s_ar_prot, s_ar_qos, s_ar_lock}, {4'b0011, 8'h00});
    s_ar_ready = 1'b1;
    #1 chk({tag, "/ar_ready"}, {m1_ar_ready, m0_ar_ready}, own ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    m0_ar_valid = 1'b0; m1_ar_valid = 1'b0; s_ar_ready = 1'b0;
    m0_r_ready = 1'b1; m1_r_ready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      d = 64'hA5A5_0000_0000_0000 | (64'(len) << 8) | 64'(b);
      s_r_valid = 1'b1; s_r_data = d; s_r_last = (b == int'(len));
      s_r_id = own ? 6'd12 : 6'd3; s_r_resp = 2'b00;
      #1;
      chk({tag, "/r_valid"}, {m1_r_valid, m0_r_valid}, own ? 2'b10 : 2'b01);
      chk({tag, "/r_data"}, own ? m1_r_data : m0_r_data, d);
      chk({tag, "/r_last_ready"}, {own ? m1_r_last : m0_r_last, s_r_ready}, {b == int'(len), 1'b1});
      @(posedge clk); #1;
    end
    s_r_valid = 1'b0; s_r_last = 1'b0;
    m0_r_ready = 1'b0; m1_r_ready = 1'b0;
    #1 chk({tag, "/idle_after"}, {s_ar_valid, rd_owner}, {1'b0, own});
  endtask

  typedef struct {
    logic r0; logic r1;
    logic [31:0] a0; logic [31:0] a1;
    logic [7:0] len;
    logic own;
    logic [31:0] ea_on; logic [31:0] ea_off;
  } rd_vec_t;

  rd_vec_t vec[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Pointer starts at M0; each completed burst points it at the other master.
    vec[0] = '{1'b1, 1'b0, 32'h0000_1000, 32'h5000_0000, 8'd3, 1'b0, 32'h1000_1000, 32'h0000_1000};
    vec[1] = '{1'b1, 1'b1, 32'h2000_0040, 32'h3000_0000, 8'd1, 1'b1, 32'h3000_0000, 32'h3000_0000};
    vec[2] = '{1'b1, 1'b1, 32'h2000_0040, 32'h3000_0004, 8'd0, 1'b0, 32'h4000_0040, 32'h2000_0040};
    vec[3] = '{1'b1, 1'b0, 32'hF000_0008, 32'h0000_0000, 8'd0, 1'b0, 32'h1000_0008, 32'hF000_0008};
    vec[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h2000_0000, 8'd2, 1'b1, 32'h2000_0000, 32'h2000_0000};
    vec[5] = '{1'b1, 1'b1, 32'h2FFF_FFFC, 32'h1234_5678, 8'd1, 1'b0, 32'h4FFF_FFFC, 32'h2FFF_FFFC};
    vec[6] = '{1'b1, 1'b1, 32'h0000_0000, 32'h1234_5678, 8'd0, 1'b1, 32'h1234_5678, 32'h1234_5678};

    reset_n = 1'b0;
    {m0_ar_valid, m0_ar_addr, m0_ar_id, m0_ar_len, m0_r_ready} = '0;
    {m1_ar_valid, m1_ar_addr, m1_ar_id, m1_ar_len, m1_r_ready} = '0;
    {m0_aw_valid, m0_aw_addr, m0_aw_id, m0_aw_len, m0_w_valid, m0_w_data, m0_w_strb, m0_w_last, m0_b_ready} = '0;
    {m1_aw_valid, m1_aw_addr, m1_aw_id, m1_aw_len, m1_w_valid, m1_w_data, m1_w_strb, m1_w_last, m1_b_ready} = '0;
    m0_ar_size = 3'd3; m1_ar_size = 3'd3; m0_aw_size = 3'd3; m1_aw_size = 3'd3;
    m0_ar_burst = 2'd1; m1_ar_burst = 2'd1; m0_aw_burst = 2'd1; m1_aw_burst = 2'd1;
    {s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_resp, s_r_last} = '0;
    {s_aw_ready, s_w_ready, s_b_valid, s_b_id, s_b_resp} = '0;

    repeat (3) @(posedge clk);
    #1 chk_quiet("reset");
    reset_n = 1'b1;

    foreach (vec[i])
      rd_txn($sformatf("rd%0d", i), vec[i].r0, vec[i].r1, vec[i].a0, vec[i].a1,
             vec[i].len, vec[i].own, rm(vec[i].ea_on, vec[i].ea_off));

    // M1 write with M0 W held valid, concurrent with an M0 read.
    m1_aw_valid = 1'b1; m1_aw_addr = 32'h2000_0100; m1_aw_len = 8'd1; m1_aw_id = 6'd7;
    m0_w_valid = 1'b1; m0_w_data = 64'hDEAD_BEEF_0000_0001; m0_w_strb = 8'hFF; m0_w_last = 1'b1;
    s_w_ready = 1'b1;
    m0_ar_valid = 1'b1; m0_ar_addr = 32'h0000_2000; m0_ar_len = 8'd0; m0_ar_id = 6'd3;
    #1 chk("wr/m0_wready_idle", m0_w_ready, 1'b0);
    @(posedge clk); #1;
    chk("wr/aw_valid_owner", {s_aw_valid, wr_owner}, 2'b11);
    chk("wr/aw_addr_id", {s_aw_addr, s_aw_id}, {32'h2000_0100, 6'd7});
    chk("wr/w_blocked_addr", {s_w_valid, m0_w_ready, m1_w_ready}, 3'b000);
    chk("wr/rd_concurrent", {s_ar_valid, rd_owner}, 2'b10);
    chk("wr/ar_addr", s_ar_addr, rm(32'h1000_2000, 32'h0000_2000));
    s_aw_ready = 1'b1; s_ar_ready = 1'b1;
    #1 chk("wr/aw_ar_ready", {m1_aw_ready, m0_aw_ready, m0_ar_ready, m1_ar_ready}, 4'b1010);
    @(posedge clk); #1;
    m1_aw_valid = 1'b0; m0_ar_valid = 1'b0; s_aw_ready = 1'b0; s_ar_ready = 1'b0;
    m1_w_valid = 1'b1; m1_w_data = 64'h1111; m1_w_strb = 8'h0F; m1_w_last = 1'b0;
    s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = 64'h2222; m0_r_ready = 1'b1;
    #1;
    chk("wr/beat0", {s_w_valid, s_w_data, s_w_strb, s_w_last}, {1'b1, 64'h1111, 8'h0F, 1'b0});
    chk("wr/wready_beat0", {m1_w_ready, m0_w_ready}, 2'b10);
    chk("wr/rd_beat", {m0_r_valid, m1_r_valid, s_r_ready, m0_r_data}, {3'b101, 64'h2222});
    @(posedge clk); #1;
    s_r_valid = 1'b0; s_r_last = 1'b0; m0_r_ready = 1'b0;
    m1_w_data = 64'h3333; m1_w_strb = 8'hFF; m1_w_last = 1'b1;
    #1;
    chk("wr/beat1", {s_w_valid, s_w_data, s_w_last, m0_w_ready}, {1'b1, 64'h3333, 1'b1, 1'b0});
    chk("wr/rd_done", {s_ar_valid, s_r_ready}, 2'b00);
    @(posedge clk); #1;
    m1_w_valid = 1'b0;
    s_b_valid = 1'b1; s_b_id = 6'd7; s_b_resp = 2'b10; m1_b_ready = 1'b1;
    #1;
    chk("wr/resp_w_stalled", {s_w_valid, m0_w_ready}, 2'b00);
    chk("wr/b_route", {m1_b_valid, m0_b_valid, s_b_ready}, 3'b101);
    chk("wr/b_id_resp", {m1_b_id, m1_b_resp}, {6'd7, 2'b10});
    @(posedge clk); #1;
    s_b_valid = 1'b0; m1_b_ready = 1'b0;
    m0_aw_valid = 1'b1; m0_aw_addr = 32'h2000_0040; m0_aw_len = 8'd0; m0_aw_id = 6'd1;
    #1 chk("wr2/idle_gap", {s_aw_valid, m0_w_ready}, 2'b00);
    @(posedge clk); #1;
    chk("wr2/owner_addr", {wr_owner, s_aw_valid, s_aw_addr},
        {2'b01, rm(32'h4000_0040, 32'h2000_0040)});
    s_aw_ready = 1'b1;
    @(posedge clk); #1;
    m0_aw_valid = 1'b0; s_aw_ready = 1'b0;
    #1 chk("wr2/m0_w_granted", {m0_w_ready, m1_w_ready, s_w_data}, {2'b10, 64'hDEAD_BEEF_0000_0001});
    @(posedge clk); #1;
    m0_w_valid = 1'b0;
    s_b_valid = 1'b1; s_b_id = 6'd1; s_b_resp = 2'b00; m0_b_ready = 1'b1;
    #1 chk("wr2/b_route", {m0_b_valid, m1_b_valid, m0_b_id}, {2'b10, 6'd1});
    @(posedge clk); #1;
    s_b_valid = 1'b0; m0_b_ready = 1'b0;

    // Reset during R beat 2 of 4 of an M1 burst.
    m1_ar_valid = 1'b1; m1_ar_addr = 32'h6000_0000; m1_ar_len = 8'd3; m1_ar_id = 6'd12;
    @(posedge clk); #1;
    s_ar_ready = 1'b1;
    @(posedge clk); #1;
    m1_ar_valid = 1'b0; s_ar_ready = 1'b0;
    s_r_valid = 1'b1; s_r_last = 1'b0; s_r_data = 64'h10; m1_r_ready = 1'b1;
    @(posedge clk); #1;
    s_r_data = 64'h11;
    #1 chk("rst/beat2_live", {m1_r_valid, rd_owner}, 2'b11);
    reset_n = 1'b0;
    #1 chk_quiet("rst/async");
    @(posedge clk); #1;
    reset_n = 1'b1; s_r_valid = 1'b0; m1_r_ready = 1'b0;
    rd_txn("rst/m1_first", 1'b0, 1'b1, 32'h0, 32'h6000_0010, 8'd0, 1'b1, 32'h6000_0010);

    // Fresh reset, simultaneous requests: M0 first, then M1.
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd_txn("sim/m0", 1'b1, 1'b1, 32'h0000_3000, 32'h7000_0000, 8'd1, 1'b0, rm(32'h1000_3000, 32'h0000_3000));
    rd_txn("sim/m1", 1'b0, 1'b1, 32'h0000_3000, 32'h7000_0000, 8'd1, 1'b1, 32'h7000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hp_port_arbiter.md
# hp_port_arbiter

Two-master AXI4 arbiter that lets the Rocket memory port (master 0) and the VDMA frame engine (master 1) share the single 64-bit Zynq HP slave port into DDR. The read and write channels are arbitrated independently, with round-robin fairness and one burst outstanding per channel. Optionally, it applies the Rocket DRAM window remap to master-0 addresses. It sits between `Top`/VDMA and the `system` S_AXI port, clocked by the host clock.

## Interface
Parameters:
- `ID_W`, 6, AXI ID width on all ports.
- `DATA_W`, 64, data width; strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1  host clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `mN_ar_{valid,addr,id,len,size,burst}`  in  1/32/ID_W/8/3/2  read address from master N (N=0,1).
- `mN_ar_ready`  out  1.
- `mN_r_{valid,data,id,resp,last}`  out  1/DATA_W/ID_W/2/1.
- `mN_r_ready`  in  1.
- `mN_aw_{valid,addr,id,len,size,burst}`  in  same widths as AR.
- `mN_aw_ready`  out  1.
- `mN_w_{valid,data,strb,last}`  in  1/DATA_W/DATA_W/8/1.
- `mN_w_ready`  out  1.
- `mN_b_{valid,id,resp}`  out  1/ID_W/2.
- `mN_b_ready`  in  1.
- `s_ar_*`, `s_aw_*`, `s_w_*`  out, `s_r_*`, `s_b_*`  in; mirror of the master bundles toward the HP port; `s_*_ready` directions are inverted accordingly.
- `rd_owner`, `wr_owner`  out  1  current or last grant, for debug.

## Operation
- **Read FSM (IDLE, ADDR, DATA).**
  - IDLE: pick a requester among `mN_ar_valid` using round-robin. The priority pointer points at the master not granted last. Register the grant, then go to ADDR.
  - ADDR: forward the granted AR to `s_ar_*`. Assert the granted `mN_ar_ready = s_ar_ready`. The AR handshake moves the FSM to DATA.
  - DATA: route `s_r_*` to the granted master and `mN_r_ready` back. The other master sees `r_valid=0`. The handshake with `last=1` returns the FSM to IDLE and flips the pointer.
- **Write FSM (IDLE, ADDR, DATA, RESP).**
  - Arbitration mirrors the read FSM, on `mN_aw_valid`.
  - DATA: route W of the granted master only. The handshake with `w_last=1` moves the FSM to RESP.
  - RESP: route `s_b_*` to the granted master. The B handshake returns the FSM to IDLE.
  - W beats issued by the ungranted master are stalled (`w_ready=0`).
- Non-granted masters always see `ar_ready`, `aw_ready`, `w_ready`, `r_valid` and `b_valid` at 0.
- `len`, `size`, `burst`, `id`, `data`, `strb` and `resp` pass through unmodified. Only `addr` may change (see Configuration).
- `s_ar_cache`, `s_aw_cache` = 4'b0011; `prot` = 0; `qos` = 0; `lock` = 0.

## Timing
- Reset (`reset_n` low, asynchronous):
  - Both FSMs return to IDLE.
  - Pointers reset to master 0.
  - `rd_owner = wr_owner = 0`.
  - All `valid`/`ready` outputs are 0.
- Reset asserted mid-burst aborts the burst with no drain. Cleanup is the system's responsibility.
- Grant latency: the first request cycle registers the grant. `s_ar_valid`/`s_aw_valid` are asserted on the next cycle, so there is 1 cycle of latency from IDLE.
- The master's AR/AW fields must stay stable while valid (AXI rule). The arbiter forwards them combinationally in ADDR.
- R, W and B paths are combinational pass-through once granted, giving zero added latency per beat.
- Simultaneous requests in IDLE: the pointer wins. A single requester wins regardless of the pointer.
- Back-to-back: the cycle after the last R/B handshake is IDLE, so the gap between bursts is at least 1 cycle.
- Read and write channels run fully concurrently and may be granted to different masters.

## Configuration
- `HP_ARB_REMAP_EN` defined:
  - Master-0 addresses are remapped: `addr[31:28]==2` becomes `{4'd4, addr[27:0]}`.
  - Any other value becomes `{4'd1, addr[27:0]}`.
  - Master-1 addresses always pass through unmodified.
- Not defined: all addresses pass through unmodified.

## Test plan
- Reset, then M0 AR addr=0x0000_1000 len=3 → one cycle later `s_ar_addr`=0x1000_1000 (REMAP_EN). Four R beats go to M0 only; `rd_owner`=0.
- M0 and M1 assert AR in the same cycle, after reset → M0 is served first, then M1. `rd_owner` sequence is 0, 1.
- M1 AW len=1 with two W beats, while M0 W is valid throughout → M0 `w_ready` stays 0 until M1's B handshake completes. `s_b_id` returns on `m1_b_id`.
- M0 AR addr=0x2000_0040 → `s_ar_addr`=0x4000_0040 with REMAP_EN, 0x2000_0040 without it.
- Concurrent M0 read and M1 write bursts → both complete with no stall from cross-channel interaction.
- `reset_n` pulsed low during the R beat 2 of 4 → outputs are 0 immediately. After release, M1 is granted first on a new request.
